nibble_feeder: RTL and testbench

//   Buffered source stage directly upstream of the serial bus master m1.

---
 rtl/nibble_feeder.sv | 160 ++++++++++++++++
 tb/tb_nibble_feeder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_feeder.sv
// Buffered nibble source in front of serial master m1: a DEPTH-entry FIFO fed over
// valid/ready, with a registered date/date_vld output stage advanced by rising edges of ack.
module nibble_feeder #(
    parameter int DW    = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          sclk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          ack,
    output logic [DW-1:0] date,
    output logic          date_vld,
    output logic [AW:0]   fifo_cnt,
    output logic          underrun
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [DW-1:0] r_date;
    logic          r_ack_d;
    logic          r_underrun;

    logic          w_full;
    logic          w_nonempty;
    logic          w_push;
    logic          w_pop;
    logic          w_ack_rise;
    logic          w_set_underrun;

    assign w_full     = (r_cnt == CNT_FULL);
    assign w_nonempty = (r_cnt != CNT_ZERO);
    // No lookahead: a pop at full does not open the door for a push in the same cycle.
    assign w_push     = in_valid & ~w_full;
    assign w_ack_rise = ack & ~r_ack_d;

    // Next-state decode: decides when the output stage reloads from the FIFO.
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_set_underrun = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_set_underrun = w_ack_rise;
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (w_ack_rise) begin
                    if (w_nonempty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and ack edge history.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ack_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack_d <= ack;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_wp  <= {AW{1'b0}};
            r_rp  <= {AW{1'b0}};
            r_cnt <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_ONE;
            end else begin
                r_wp <= r_wp;
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_ONE;
            end else begin
                r_rp <= r_rp;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DW{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wp] <= in_data;
        end else begin
            r_mem[r_wp] <= r_mem[r_wp];
        end
    end

    // Output stage: date keeps its last value when the FIFO runs dry.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_date     <= {DW{1'b0}};
            r_underrun <= 1'b0;
        end else begin
            if (w_pop) begin
                r_date <= r_mem[r_rp];
            end else begin
                r_date <= r_date;
            end
            if (w_set_underrun) begin
                r_underrun <= 1'b1;
            end else begin
                r_underrun <= r_underrun;
            end
        end
    end

    assign in_ready = ~w_full;
    assign date     = r_date;
    assign date_vld = (r_state == ST_HOLD);
    assign fifo_cnt = r_cnt;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_nibble_feeder.sv
// Directed self-checking bench for nibble_feeder; inputs driven and outputs sampled on negedge.
module tb_nibble_feeder;

    logic       sclk;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ack;
    logic [3:0] date;
    logic       date_vld;
    logic [3:0] fifo_cnt;
    logic       underrun;

    int n_cmp;
    int n_err;

    nibble_feeder #(.DW(4), .DEPTH(8), .AW(3)) dut (
        .sclk     (sclk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ack      (ack),
        .date     (date),
        .date_vld (date_vld),
        .fifo_cnt (fifo_cnt),
        .underrun (underrun)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic apply_reset();
        @(negedge sclk);
        rst      = 1'b0;
        in_valid = 1'b0;
        ack      = 1'b0;
        repeat (2) @(negedge sclk);
        rst = 1'b1;
    endtask

    task automatic push_one(input logic [3:0] d, output logic acc);
        @(negedge sclk);
        in_data  = d;
        in_valid = 1'b1;
        acc      = in_ready;
        @(posedge sclk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic ack_pulse(input int w);
        @(negedge sclk);
        ack = 1'b1;
        repeat (w) @(negedge sclk);
        ack = 1'b0;
        repeat (2) @(negedge sclk);
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (date !== 4'h0) begin n_err++; $display("FAIL rst_date: got %0h expected 0", date); end
        n_cmp++; if (date_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %0b expected 0", date_vld); end
        n_cmp++; if (fifo_cnt !== 4'd0) begin n_err++; $display("FAIL rst_cnt: got %0d expected 0", fifo_cnt); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL rst_underrun: got %0b expected 0", underrun); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b expected 1", in_ready); end
        @(negedge sclk);
        rst = 1'b1;
    endtask

    task automatic test_fill();
        logic acc;
        logic exp_acc;
        for (int i = 0; i < 10; i++) begin
            push_one(4'(i), acc);
            exp_acc = (i <= 8) ? 1'b1 : 1'b0;
            n_cmp++;
            if (acc !== exp_acc) begin n_err++; $display("FAIL fill_ready[%0d]: got %0b expected %0b", i, acc, exp_acc); end
        end
        @(negedge sclk);
        n_cmp++; if (date !== 4'h0) begin n_err++; $display("FAIL fill_date: got %0h expected 0", date); end
        n_cmp++; if (date_vld !== 1'b1) begin n_err++; $display("FAIL fill_vld: got %0b expected 1", date_vld); end
        n_cmp++; if (fifo_cnt !== 4'd8) begin n_err++; $display("FAIL fill_cnt: got %0d expected 8", fifo_cnt); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready_full: got %0b expected 0", in_ready); end
    endtask

    task automatic test_drain();
        logic       exp_vld;
        logic [3:0] exp_date;
        logic [3:0] exp_cnt;
        logic       exp_ur;
        for (int j = 1; j <= 10; j++) begin
            ack_pulse((j % 3) + 1);
            exp_vld  = (j <= 8) ? 1'b1 : 1'b0;
            exp_date = (j <= 8) ? 4'(j) : 4'h8;
            exp_cnt  = (j <= 8) ? 4'(8 - j) : 4'd0;
            exp_ur   = (j == 10) ? 1'b1 : 1'b0;
            n_cmp++; if (date !== exp_date) begin n_err++; $display("FAIL drain_date[%0d]: got %0h expected %0h", j, date, exp_date); end
            n_cmp++; if (date_vld !== exp_vld) begin n_err++; $display("FAIL drain_vld[%0d]: got %0b expected %0b", j, date_vld, exp_vld); end
            n_cmp++; if (fifo_cnt !== exp_cnt) begin n_err++; $display("FAIL drain_cnt[%0d]: got %0d expected %0d", j, fifo_cnt, exp_cnt); end
            n_cmp++; if (underrun !== exp_ur) begin n_err++; $display("FAIL drain_underrun[%0d]: got %0b expected %0b", j, underrun, exp_ur); end
        end
    endtask

    task automatic test_reset_mid();
        logic acc;
        push_one(4'h5, acc);
        push_one(4'h6, acc);
        @(negedge sclk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (date !== 4'h0) begin n_err++; $display("FAIL mid_rst_date: got %0h expected 0", date); end
        n_cmp++; if (date_vld !== 1'b0) begin n_err++; $display("FAIL mid_rst_vld: got %0b expected 0", date_vld); end
        n_cmp++; if (fifo_cnt !== 4'd0) begin n_err++; $display("FAIL mid_rst_cnt: got %0d expected 0", fifo_cnt); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL mid_rst_underrun: got %0b expected 0", underrun); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %0b expected 1", in_ready); end
        #9;
        rst = 1'b1;
        repeat (3) @(negedge sclk);
        n_cmp++; if (date_vld !== 1'b0) begin n_err++; $display("FAIL mid_rst_discard_vld: got %0b expected 0", date_vld); end
        n_cmp++; if (fifo_cnt !== 4'd0) begin n_err++; $display("FAIL mid_rst_discard_cnt: got %0d expected 0", fifo_cnt); end
    endtask

    task automatic test_wrap();
        logic       acc;
        logic [3:0] exp_date;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) begin
                push_one(4'((4 * r) + k), acc);
            end
            @(negedge sclk);
            exp_date = 4'(4 * r);
            n_cmp++; if (date !== exp_date) begin n_err++; $display("FAIL wrap_first[%0d]: got %0h expected %0h", r, date, exp_date); end
            n_cmp++; if (fifo_cnt > 4'd5) begin n_err++; $display("FAIL wrap_cnt_max[%0d]: got %0d expected <=5", r, fifo_cnt); end
            for (int k = 1; k < 4; k++) begin
                ack_pulse(1);
                exp_date = 4'((4 * r) + k);
                n_cmp++; if (date !== exp_date) begin n_err++; $display("FAIL wrap_date[%0d.%0d]: got %0h expected %0h", r, k, date, exp_date); end
            end
            ack_pulse(1);
            n_cmp++; if (date_vld !== 1'b0) begin n_err++; $display("FAIL wrap_idle[%0d]: got %0b expected 0", r, date_vld); end
        end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL wrap_underrun: got %0b expected 0", underrun); end
    endtask

    task automatic test_simultaneous();
        logic       acc;
        logic [3:0] exp_date;
        apply_reset();
        push_one(4'hA, acc);
        push_one(4'hB, acc);
        push_one(4'hC, acc);
        push_one(4'hD, acc);
        @(negedge sclk);
        n_cmp++; if (fifo_cnt !== 4'd3) begin n_err++; $display("FAIL sim_pre_cnt: got %0d expected 3", fifo_cnt); end
        n_cmp++; if (date !== 4'hA) begin n_err++; $display("FAIL sim_pre_date: got %0h expected a", date); end
        in_data  = 4'hE;
        in_valid = 1'b1;
        ack      = 1'b1;
        @(posedge sclk);
        #1;
        in_valid = 1'b0;
        @(negedge sclk);
        ack = 1'b0;
        n_cmp++; if (fifo_cnt !== 4'd3) begin n_err++; $display("FAIL sim_cnt: got %0d expected 3", fifo_cnt); end
        n_cmp++; if (date !== 4'hB) begin n_err++; $display("FAIL sim_date: got %0h expected b", date); end
        for (int k = 0; k < 3; k++) begin
            ack_pulse(1);
            exp_date = 4'(12 + k);
            n_cmp++; if (date !== exp_date) begin n_err++; $display("FAIL sim_tail[%0d]: got %0h expected %0h", k, date, exp_date); end
        end
        n_cmp++; if (fifo_cnt !== 4'd0) begin n_err++; $display("FAIL sim_end_cnt: got %0d expected 0", fifo_cnt); end
    endtask

    task automatic test_system();
        int         sent;
        int         got;
        logic       rdy_q;
        logic [3:0] rx [16];
        apply_reset();
        sent  = 0;
        got   = 0;
        rdy_q = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            @(negedge sclk);
            if (in_valid && rdy_q) sent++;
            if (sent < 16) begin
                in_valid = 1'b1;
                in_data  = 4'(sent);
                rdy_q    = in_ready;
            end else begin
                in_valid = 1'b0;
                rdy_q    = 1'b0;
            end
            if (ack) begin
                ack = 1'b0;
            end else if (date_vld) begin
                rx[got] = date;
                got++;
                ack = 1'b1;
            end
        end
        @(negedge sclk);
        ack      = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (got !== 16) begin n_err++; $display("FAIL sys_timeout: got %0d nibbles expected 16", got); end
        for (int i = 0; i < got; i++) begin
            n_cmp++; if (rx[i] !== 4'(i)) begin n_err++; $display("FAIL sys_order[%0d]: got %0h expected %0h", i, rx[i], 4'(i)); end
        end
        repeat (2) @(negedge sclk);
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL sys_underrun: got %0b expected 0", underrun); end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        in_data  = 4'h0;
        in_valid = 1'b0;
        ack      = 1'b0;
        #1;
        rst = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_reset_mid();
        test_wrap();
        test_simultaneous();
        test_system();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
